object_ram_arbiter: RTL
=======================

OBJECT_RAM_ARBITER -- requirements
Module: object_ram_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from RAM address sample to ram_q valid; legal values 1 and 2.
REQ-002 clock  input  1  system clock; all logic on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 req  input  3  per-requester request; bit0 rope 1, bit1 rope 2, bit2 stone renderer.
REQ-005 wr  input  3  per-requester operation; 1 = write, 0 = read.
REQ-006 addr0, addr1, addr2  input  4 each  object index per requester.
REQ-007 wdata0, wdata1, wdata2  input  32 each  write word per requester (x 31:23, y 18:11, type 3:2, visible 1, moving 0).
REQ-008 ack  output  3  one-hot, one-cycle completion pulse to the owning requester.
REQ-009 rdata  output  32  read word; valid only in the cycle ack is high.
REQ-010 ram_address  output  4  object RAM address.
REQ-011 ram_data  output  32  object RAM write data.
REQ-012 ram_wren  output  1  object RAM write enable.
REQ-013 ram_q  input  32  object RAM read data.
REQ-014 busy  output  1  high in every state except S_IDLE.
REQ-015 owner  output  2  index of the requester currently being served; 3 = none.

Function
REQ-016 FSM states: S_IDLE, S_ISSUE, S_WAIT, S_ACK. All outputs are registered.
REQ-017 S_IDLE: if any req bit is high, select a winner round-robin from pointer rr_ptr and go to S_ISSUE. Otherwise stay in S_IDLE.
REQ-018 Round-robin order: search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, rr_ptr+2, mod 3. rr_ptr resets to 0.
REQ-019 On entry to S_ISSUE, latch the winner's addr, wr and wdata into ram_address, ram_wren and ram_data, and set owner.
REQ-020 ram_wren is high for exactly the single S_ISSUE cycle of a write and is 0 at all other times.
REQ-021 S_ISSUE always goes to S_WAIT. S_WAIT lasts RD_LAT cycles, counted by a wait counter.
REQ-022 In the last S_WAIT cycle, register ram_q into rdata (reads only; on writes rdata holds its previous value), then go to S_ACK.
REQ-023 S_ACK: ack[owner] = 1, all other ack bits 0. Set rr_ptr = (owner+1) mod 3, set owner = 3, go to S_IDLE.
REQ-024 Latency: with req first seen high in S_IDLE in cycle 0, ack is high in cycle 2+RD_LAT; reads and writes have equal latency.
REQ-025 Requesters hold req, wr, addr and wdata stable until they see ack, and deassert req on the same edge that ack is sampled. S_IDLE then evaluates the updated req.
REQ-026 A req that drops before it is granted is discarded with no RAM access.
REQ-027 A req that drops after grant does not abort the transaction: the access completes and ack still pulses.
REQ-028 Only one transaction is in flight at a time; req bits are ignored outside S_IDLE.
REQ-029 Simultaneous writes to the same address are serialized in round-robin order; the last-served write persists.
REQ-030 Fairness: a continuously held req is acked within 3*(RD_LAT+3) cycles.
REQ-031 Unreachable state encodings return to S_IDLE on the next edge with ram_wren = 0.

Reset
REQ-032 While resetn = 0 at a clock edge, the next state is: S_IDLE, ack = 0, ram_wren = 0, ram_address = 0, ram_data = 0, rdata = 0, rr_ptr = 0, owner = 3, busy = 0, wait counter = 0.
REQ-033 Reset mid-transaction abandons the transaction with no ack and no further write; a write already sampled by the RAM stands.

Structure
REQ-034 Shared package object_ram_pkg holds: OBJ_ADDR_W = 4; OBJ_DATA_W = 32; requester indices REQ_ROPE1/REQ_ROPE2/REQ_DRAW; OWNER_NONE = 3; FSM state encoding; object word field positions.
REQ-035 Single module. The round-robin selection is a function in object_ram_pkg; no sub-module is instantiated. The RAM itself stays outside this block.

Verification
REQ-036 Single read: RD_LAT=1, RAM[5] = 32'h1234_5678, req = 3'b001, wr = 0, addr0 = 5 in cycle 0 -> ack = 3'b001 and rdata = 32'h1234_5678 in cycle 3; ram_wren stays 0.
REQ-037 Write then read back: rope 2 writes 32'hDEAD_BEE3 to address 2 -> ram_wren high exactly 1 cycle with ram_address = 2. A following renderer read of address 2 -> rdata = 32'hDEAD_BEE3.
REQ-038 Three-way contention from reset: req = 3'b111 held, each requester dropping its bit on its own ack -> ack order 001, 010, 100; acks 4 cycles apart at RD_LAT=1.
REQ-039 Same-address race: ropes 1 and 2 write 32'hA and 32'hB to address 7 simultaneously, rr_ptr = 0 -> final RAM[7] = 32'hB.
REQ-040 Reset during S_WAIT of a read -> no ack; next cycle busy = 0 and owner = 3. A fresh req is then served with rr_ptr = 0.
REQ-041 RD_LAT=2 read -> ack in cycle 4; rdata equals the RAM contents.

Source files
------------

// File: rtl/object_ram_pkg.sv
// Shared types for the object RAM arbiter: FSM states, requester indices, object word layout,
// and the round-robin pick function.
package object_ram_pkg;

    localparam int OBJ_ADDR_W = 4;
    localparam int OBJ_DATA_W = 32;
    localparam int NUM_REQ    = 3;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_ROPE1  = 2'd0;
    localparam req_idx_t REQ_ROPE2  = 2'd1;
    localparam req_idx_t REQ_DRAW   = 2'd2;
    localparam req_idx_t OWNER_NONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } arb_state_t;

    // Object word layout
    localparam int OBJ_X_HI        = 31;
    localparam int OBJ_X_LO        = 23;
    localparam int OBJ_Y_HI        = 18;
    localparam int OBJ_Y_LO        = 11;
    localparam int OBJ_TYPE_HI     = 3;
    localparam int OBJ_TYPE_LO     = 2;
    localparam int OBJ_VISIBLE_BIT = 1;
    localparam int OBJ_MOVING_BIT  = 0;

    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == REQ_DRAW) ? REQ_ROPE1 : idx + 2'd1;
    endfunction

    // First requesting index, searching ptr, ptr+1, ptr+2 (mod 3); OWNER_NONE if none.
    function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] req, input req_idx_t ptr);
        req_idx_t idx;
        req_idx_t pick;
        idx  = ptr;
        pick = OWNER_NONE;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (pick == OWNER_NONE && req[idx]) pick = idx;
            idx = rr_next(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/object_ram_arbiter.sv
// Round-robin arbiter giving three requesters one-at-a-time access to the object RAM.
// Ack arrives 2+RD_LAT cycles after req is seen in idle; requests are ignored while a transaction is in flight.
module object_ram_arbiter
    import object_ram_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    wr,
    input  logic [OBJ_ADDR_W-1:0] addr0,
    input  logic [OBJ_ADDR_W-1:0] addr1,
    input  logic [OBJ_ADDR_W-1:0] addr2,
    input  logic [OBJ_DATA_W-1:0] wdata0,
    input  logic [OBJ_DATA_W-1:0] wdata1,
    input  logic [OBJ_DATA_W-1:0] wdata2,
    output logic [NUM_REQ-1:0]    ack,
    output logic [OBJ_DATA_W-1:0] rdata,
    output logic [OBJ_ADDR_W-1:0] ram_address,
    output logic [OBJ_DATA_W-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [OBJ_DATA_W-1:0] ram_q,
    output logic                  busy,
    output logic [1:0]            owner
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    arb_state_t            state_q;
    req_idx_t              rr_ptr_q;
    req_idx_t              owner_q;
    logic [1:0]            wait_cnt_q;
    logic                  op_wr_q;
    logic                  busy_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [OBJ_DATA_W-1:0] rdata_q;
    logic [OBJ_ADDR_W-1:0] ram_address_q;
    logic [OBJ_DATA_W-1:0] ram_data_q;
    logic                  ram_wren_q;

    req_idx_t              winner_d;
    logic [OBJ_ADDR_W-1:0] sel_addr_d;
    logic [OBJ_DATA_W-1:0] sel_wdata_d;
    logic                  sel_wr_d;

    always_comb begin
        winner_d    = rr_pick(req, rr_ptr_q);
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        sel_wr_d    = 1'b0;
        case (winner_d)
            REQ_ROPE1: begin sel_addr_d = addr0; sel_wdata_d = wdata0; sel_wr_d = wr[0]; end
            REQ_ROPE2: begin sel_addr_d = addr1; sel_wdata_d = wdata1; sel_wr_d = wr[1]; end
            REQ_DRAW:  begin sel_addr_d = addr2; sel_wdata_d = wdata2; sel_wr_d = wr[2]; end
            default:   ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= REQ_ROPE1;
            owner_q       <= OWNER_NONE;
            wait_cnt_q    <= '0;
            op_wr_q       <= 1'b0;
            busy_q        <= 1'b0;
            ack_q         <= '0;
            rdata_q       <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            // Write strobe and ack are single-cycle pulses unless re-armed below.
            ack_q      <= '0;
            ram_wren_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q       <= S_ISSUE;
                        owner_q       <= winner_d;
                        ram_address_q <= sel_addr_d;
                        ram_data_q    <= sel_wdata_d;
                        ram_wren_q    <= sel_wr_d;
                        op_wr_q       <= sel_wr_d;
                        busy_q        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        if (!op_wr_q) rdata_q <= ram_q;
                        ack_q      <= 3'b001 << owner_q;
                        wait_cnt_q <= '0;
                        state_q    <= S_ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                S_ACK: begin
                    rr_ptr_q <= rr_next(owner_q);
                    owner_q  <= OWNER_NONE;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    owner_q <= OWNER_NONE;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

endmodule
